fwd_tnew_pipe: RTL and testbench

FWD_TNEW_PIPE -- requirements
Module: fwd_tnew_pipe

---
 rtl/fwd_tnew_pipe_pkg.sv | 30 +++
 rtl/fwd_lookup.sv | 78 +++++++
 rtl/fwd_tnew_pipe.sv | 106 ++++++++++
 tb/tb_fwd_tnew_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_tnew_pipe_pkg.sv
// rtl/fwd_tnew_pipe_pkg.sv - shared encodings and stage record for the forwarding pipe
package fwd_tnew_pipe_pkg;

    // Source-select encodings seen on rs_sel / rt_sel
    localparam logic [1:0] SEL_GRF = 2'd0;
    localparam logic [1:0] SEL_E   = 2'd1;
    localparam logic [1:0] SEL_M   = 2'd2;
    localparam logic [1:0] SEL_W   = 2'd3;

    // Cycles from E entry until the result exists, per instruction class
    localparam logic [1:0] TNEW_JAL  = 2'd0;
    localparam logic [1:0] TNEW_CAL  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // Widest register address a stage record can carry; AW must not exceed it
    localparam int MAX_AW = 8;

    // One pipeline stage's view of the instruction it holds
    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] wa;
        logic [1:0]        tnew;
    } stage_t;

    // tnew ages by one cycle per stage hop and never wraps below zero
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/fwd_lookup.sv
// rtl/fwd_lookup.sv - per-source forwarding select and hazard detection
module fwd_lookup
    import fwd_tnew_pipe_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] src_addr,
    input  logic [1:0]    tuse,
    input  logic [DW-1:0] grf_data,
    input  stage_t        e_stage,
    input  stage_t        m_stage,
    input  stage_t        w_stage,
    input  logic [DW-1:0] e_wd,
    input  logic [DW-1:0] m_wd,
    input  logic [DW-1:0] w_wd,
    output logic [1:0]    sel,
    output logic [DW-1:0] data,
    output logic          hazard
);

    logic [MAX_AW-1:0] addr_ext;
    logic              e_hit;
    logic              m_hit;
    logic              w_hit;

    logic              pick_valid;
    logic [1:0]        pick_tnew;
    logic [1:0]        pick_sel;
    logic [DW-1:0]     pick_wd;

    assign addr_ext = MAX_AW'(src_addr);

    // A stage writing $0 never produces a usable value, so it cannot match
    assign e_hit = e_stage.valid && (e_stage.wa != '0) && (e_stage.wa == addr_ext);
    assign m_hit = m_stage.valid && (m_stage.wa != '0) && (m_stage.wa == addr_ext);
    assign w_hit = w_stage.valid && (w_stage.wa != '0) && (w_stage.wa == addr_ext);

    // Youngest matching stage wins, since it holds the newest value of the register
    always_comb begin
        pick_valid = 1'b0;
        pick_tnew  = 2'd0;
        pick_sel   = SEL_GRF;
        pick_wd    = grf_data;
        if (e_hit) begin
            pick_valid = 1'b1;
            pick_tnew  = e_stage.tnew;
            pick_sel   = SEL_E;
            pick_wd    = e_wd;
        end else if (m_hit) begin
            pick_valid = 1'b1;
            pick_tnew  = m_stage.tnew;
            pick_sel   = SEL_M;
            pick_wd    = m_wd;
        end else if (w_hit) begin
            pick_valid = 1'b1;
            pick_tnew  = w_stage.tnew;
            pick_sel   = SEL_W;
            pick_wd    = w_wd;
        end
    end

    // Forward a ready value now; stall only if it will arrive too late for D
    always_comb begin
        sel    = SEL_GRF;
        data   = grf_data;
        hazard = 1'b0;
        if (pick_valid) begin
            if (pick_tnew == 2'd0) begin
                sel  = pick_sel;
                data = pick_wd;
            end else if (pick_tnew > tuse) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_tnew_pipe.sv
// rtl/fwd_tnew_pipe.sv - E/M/W writer tracking with tnew/tuse forwarding and stall request
module fwd_tnew_pipe
    import fwd_tnew_pipe_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] d_wa,
    input  logic [1:0]    d_tnew,
    input  logic          stall,
    input  logic          flush,
    input  logic [DW-1:0] e_wd,
    input  logic [DW-1:0] m_wd,
    input  logic [DW-1:0] w_wd,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic [1:0]    tuse_rs,
    input  logic [1:0]    tuse_rt,
    input  logic [DW-1:0] grf_rs,
    input  logic [DW-1:0] grf_rt,
    output logic [1:0]    rs_sel,
    output logic [1:0]    rt_sel,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic          stall_req
);

    stage_t e_q, m_q, w_q;
    stage_t e_next, m_next, w_next;

    logic   rs_hazard;
    logic   rt_hazard;

    // Stall and flush both turn the D->E transfer into a bubble; $0 writers enter as bubbles too
    always_comb begin
        e_next = '0;
        if (!(stall || flush) && d_valid && (d_wa != '0)) begin
            e_next.valid = 1'b1;
            e_next.wa    = MAX_AW'(d_wa);
            e_next.tnew  = d_tnew;
        end
    end

    // Downstream stages always advance; tnew ages per hop and is zero by the time W is reached
    always_comb begin
        m_next      = e_q;
        m_next.tnew = tnew_dec(e_q.tnew);
        w_next      = m_q;
        w_next.tnew = 2'd0;
    end

    // Stage registers; reset empties the pipe immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_next;
            m_q <= m_next;
            w_q <= w_next;
        end
    end

    fwd_lookup #(
        .DW (DW),
        .AW (AW)
    ) u_rs_lookup (
        .src_addr (rs_addr),
        .tuse     (tuse_rs),
        .grf_data (grf_rs),
        .e_stage  (e_q),
        .m_stage  (m_q),
        .w_stage  (w_q),
        .e_wd     (e_wd),
        .m_wd     (m_wd),
        .w_wd     (w_wd),
        .sel      (rs_sel),
        .data     (rs_data),
        .hazard   (rs_hazard)
    );

    fwd_lookup #(
        .DW (DW),
        .AW (AW)
    ) u_rt_lookup (
        .src_addr (rt_addr),
        .tuse     (tuse_rt),
        .grf_data (grf_rt),
        .e_stage  (e_q),
        .m_stage  (m_q),
        .w_stage  (w_q),
        .e_wd     (e_wd),
        .m_wd     (m_wd),
        .w_wd     (w_wd),
        .sel      (rt_sel),
        .data     (rt_data),
        .hazard   (rt_hazard)
    );

    assign stall_req = rs_hazard | rt_hazard;

endmodule

// File: tb/tb_fwd_tnew_pipe.sv
// tb/tb_fwd_tnew_pipe.sv - scoreboard bench for fwd_tnew_pipe
module tb_fwd_tnew_pipe;
    import fwd_tnew_pipe_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic          d_valid;
    logic [AW-1:0] d_wa;
    logic [1:0]    d_tnew;
    logic          stall;
    logic          flush;
    logic [DW-1:0] e_wd, m_wd, w_wd;
    logic [AW-1:0] rs_addr, rt_addr;
    logic [1:0]    tuse_rs, tuse_rt;
    logic [DW-1:0] grf_rs, grf_rt;
    logic [1:0]    rs_sel, rt_sel;
    logic [DW-1:0] rs_data, rt_data;
    logic          stall_req;

    fwd_tnew_pipe #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_valid   (d_valid),
        .d_wa      (d_wa),
        .d_tnew    (d_tnew),
        .stall     (stall),
        .flush     (flush),
        .e_wd      (e_wd),
        .m_wd      (m_wd),
        .w_wd      (w_wd),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .tuse_rs   (tuse_rs),
        .tuse_rt   (tuse_rt),
        .grf_rs    (grf_rs),
        .grf_rt    (grf_rt),
        .rs_sel    (rs_sel),
        .rt_sel    (rt_sel),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    rs_sel;
        logic [DW-1:0] rs_data;
        logic [1:0]    rt_sel;
        logic [DW-1:0] rt_data;
        logic          stall;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference history: index = cycles since the writer entered E (0 = in E now)
    logic    h_valid [3];
    int      h_wa    [3];
    int      h_tnew  [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Youngest writer of addr decides; its remaining latency is its tnew minus age, zero once in W
    task automatic ref_lookup(input int addr, input int tuse, input logic [DW-1:0] grf,
                              output logic [1:0] sel, output logic [DW-1:0] data, output logic hz);
        logic [DW-1:0] wd [3];
        logic          found;
        int            rem;
        wd[0] = e_wd; wd[1] = m_wd; wd[2] = w_wd;
        sel = 2'd0; data = grf; hz = 1'b0; found = 1'b0;
        for (int age = 0; age < 3; age++) begin
            if (!found && h_valid[age] && addr != 0 && h_wa[age] == addr) begin
                found = 1'b1;
                rem = (age == 2) ? 0 : ((h_tnew[age] > age) ? h_tnew[age] - age : 0);
                if (rem == 0) begin
                    sel  = 2'(age + 1);
                    data = wd[age];
                end else if (rem > tuse) begin
                    hz = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            h_valid[i] = 1'b0; h_wa[i] = 0; h_tnew[i] = 0;
        end
    endtask

    task automatic apply(input logic dv, input int dwa, input int dtn, input logic stl, input logic fl,
                         input int rsa, input int rta, input int tus, input int tut);
        exp_t          ex;
        logic          hz_rs, hz_rt;
        d_valid = dv; d_wa = AW'(dwa); d_tnew = 2'(dtn);
        stall = stl; flush = fl;
        rs_addr = AW'(rsa); rt_addr = AW'(rta);
        tuse_rs = 2'(tus); tuse_rt = 2'(tut);
        e_wd = $urandom; m_wd = $urandom; w_wd = $urandom;
        grf_rs = $urandom; grf_rt = $urandom;
        #1;
        ref_lookup(rsa, tus, grf_rs, ex.rs_sel, ex.rs_data, hz_rs);
        ref_lookup(rta, tut, grf_rt, ex.rt_sel, ex.rt_data, hz_rt);
        ex.stall = hz_rs | hz_rt;
        sb_q.push_back(ex);
    endtask

    task automatic advance();
        @(posedge clk);
        h_valid[2] = h_valid[1]; h_wa[2] = h_wa[1]; h_tnew[2] = h_tnew[1];
        h_valid[1] = h_valid[0]; h_wa[1] = h_wa[0]; h_tnew[1] = h_tnew[0];
        if (stall || flush || !reset) begin
            h_valid[0] = 1'b0; h_wa[0] = 0; h_tnew[0] = 0;
        end else begin
            h_valid[0] = d_valid; h_wa[0] = int'(d_wa); h_tnew[0] = int'(d_tnew);
        end
        #1;
    endtask

    // Monitor: the lookup is combinational, so every driven cycle presents one response
    always @(negedge clk) begin
        exp_t ex;
        if (sb_q.size() > 0) begin
            ex = sb_q.pop_front();
            check("sb_rs_sel",  64'(rs_sel),    64'(ex.rs_sel));
            check("sb_rs_data", 64'(rs_data),   64'(ex.rs_data));
            check("sb_rt_sel",  64'(rt_sel),    64'(ex.rt_sel));
            check("sb_rt_data", 64'(rt_data),   64'(ex.rt_data));
            check("sb_stall",   64'(stall_req), 64'(ex.stall));
        end
    end

    initial begin
        reset = 1'b0;
        d_valid = 0; d_wa = '0; d_tnew = '0; stall = 0; flush = 0;
        e_wd = '0; m_wd = '0; w_wd = '0; rs_addr = '0; rt_addr = '0;
        tuse_rs = '0; tuse_rt = '0; grf_rs = '0; grf_rt = '0;
        clear_model();
        @(posedge clk); #1;

        // Reset state: writer offered to D while reset low, reader hits it
        apply(1, 3, TNEW_LOAD, 0, 0, 3, 3, 0, 0);
        check("rst_rs_sel", 64'(rs_sel), 64'(SEL_GRF));
        check("rst_rs_data", 64'(rs_data), 64'(grf_rs));
        check("rst_stall", 64'(stall_req), 64'd0);
        advance();
        apply(0, 0, 0, 0, 0, 3, 3, 0, 0);
        check("rst_hold_stall", 64'(stall_req), 64'd0);
        advance();
        reset = 1'b1;

        // cal_r to $8, then read rs=$8 with tuse 1 from E and from M
        apply(1, 8, TNEW_CAL, 0, 0, 0, 0, 0, 0);
        advance();
        apply(0, 0, 0, 0, 0, 8, 0, 1, 0);
        check("cal_e_rs_sel", 64'(rs_sel), 64'(SEL_GRF));
        check("cal_e_stall", 64'(stall_req), 64'd0);
        advance();
        apply(0, 0, 0, 0, 0, 8, 0, 1, 0);
        check("cal_m_rs_sel", 64'(rs_sel), 64'(SEL_M));
        check("cal_m_rs_data", 64'(rs_data), 64'(m_wd));
        check("cal_m_stall", 64'(stall_req), 64'd0);
        advance();

        // load to $9, read rt=$9 with tuse 0 while stalling two cycles
        apply(1, 9, TNEW_LOAD, 0, 0, 0, 0, 0, 0);
        advance();
        apply(1, 4, TNEW_CAL, 1, 0, 0, 9, 0, 0);
        check("load_e_stall", 64'(stall_req), 64'd1);
        advance();
        apply(1, 4, TNEW_CAL, 1, 0, 0, 9, 0, 0);
        check("load_m_stall", 64'(stall_req), 64'd1);
        advance();
        apply(0, 0, 0, 0, 0, 0, 9, 0, 0);
        check("load_w_stall", 64'(stall_req), 64'd0);
        check("load_w_rt_sel", 64'(rt_sel), 64'(SEL_W));
        check("load_w_rt_data", 64'(rt_data), 64'(w_wd));
        advance();

        // jal writes $31, read rs=$31 from E
        apply(1, 31, TNEW_JAL, 0, 0, 0, 0, 0, 0);
        advance();
        apply(0, 0, 0, 0, 0, 31, 0, 0, 0);
        check("jal_rs_sel", 64'(rs_sel), 64'(SEL_E));
        check("jal_rs_data", 64'(rs_data), 64'(e_wd));
        check("jal_stall", 64'(stall_req), 64'd0);
        advance();

        // E and M both write $5 with tnew 0: E wins
        apply(1, 5, TNEW_JAL, 0, 0, 0, 0, 0, 0);
        advance();
        apply(1, 5, TNEW_JAL, 0, 0, 0, 0, 0, 0);
        advance();
        apply(0, 0, 0, 0, 0, 5, 5, 0, 0);
        check("prio_rs_sel", 64'(rs_sel), 64'(SEL_E));
        check("prio_rt_data", 64'(rt_data), 64'(e_wd));
        advance();

        // Writer to $0 never forwards
        apply(1, 0, TNEW_JAL, 0, 0, 0, 0, 0, 0);
        advance();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("zero_rs_sel", 64'(rs_sel), 64'(SEL_GRF));
        check("zero_rs_data", 64'(rs_data), 64'(grf_rs));
        advance();

        // Reset dropped between edges with a load in E
        apply(1, 7, TNEW_LOAD, 0, 0, 0, 0, 0, 0);
        advance();
        apply(0, 0, 0, 0, 0, 0, 7, 0, 0);
        check("arst_pre_stall", 64'(stall_req), 64'd1);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check("arst_stall", 64'(stall_req), 64'd0);
        check("arst_rt_sel", 64'(rt_sel), 64'(SEL_GRF));
        check("arst_rt_data", 64'(rt_data), 64'(grf_rt));
        clear_model();
        advance();
        reset = 1'b1;

        // Flush on a writer leaves nothing to match
        apply(1, 6, TNEW_JAL, 0, 1, 0, 0, 0, 0);
        advance();
        apply(0, 0, 0, 0, 0, 6, 6, 0, 0);
        check("flush_rs_sel", 64'(rs_sel), 64'(SEL_GRF));
        advance();

        // Random traffic over a small register window to force collisions
        for (int n = 0; n < 400; n++) begin
            apply(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2), $urandom_range(0, 2));
            advance();
        end

        @(negedge clk); #1;
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
